depar_cfg_ctrl: RTL and testbench
=================================

DEPAR_CFG_CTRL -- requirements
Module: depar_cfg_ctrl

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 256: control-stream data width.
REQ-002 Parameter C_AXIS_TUSER_WIDTH, default 128: control-stream tuser width.
REQ-003 Parameter MODULE_ID, default 8'h05: ID that selects the deparser action table.
REQ-004 Parameter C_ACT_WIDTH, default 260: action-table entry width.
REQ-005 Parameter C_ACT_ADDR_WIDTH, default 4: action-table address width.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 aresetn  in  1  reset, synchronous, active-low.
REQ-008 s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  control stream in.
REQ-009 s_axis_tready  out  1  control stream backpressure.
REQ-010 m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  pass-through of non-matching control packets.
REQ-011 m_axis_tready  in  1  downstream ready.
REQ-012 act_wr_en  out  1  action-table write strobe, one cycle.
REQ-013 act_wr_addr  out  4  action-table write address.
REQ-014 act_wr_data  out  260  action-table write data.
REQ-015 cfg_wr_cnt  out  8  count of completed writes, wraps 255->0.
REQ-016 cfg_err_cnt  out  8  count of malformed packets, saturates at 255.

Function
REQ-017 Beat-0 header fields: tdata[7:0] module_id, [15:8] opcode, [19:16] index, [23:20] entry[259:256].
REQ-018 Beat 1 carries entry[255:0] = tdata[255:0].
REQ-019 FSM states: IDLE, FWD, CAP, WR, DRAIN.
REQ-020 IDLE, tvalid, module_id!=MODULE_ID: beat passes combinationally to m_axis; s_axis_tready=m_axis_tready; on handshake go FWD unless tlast (stay IDLE).
REQ-021 FWD: m_axis mirrors s_axis, s_axis_tready=m_axis_tready; return to IDLE on handshaked tlast.
REQ-022 IDLE, tvalid, module_id==MODULE_ID: s_axis_tready=1; latch index and entry[259:256]; packet is never forwarded.
REQ-023 Matching beat 0 with opcode==8'h01 and tlast=0 -> CAP; opcode!=8'h01 and tlast=0 -> DRAIN; tlast=1 -> cfg_err_cnt+1, stay IDLE.
REQ-024 CAP: s_axis_tready=1; on handshake latch entry[255:0]; tlast=1 -> WR; tlast=0 -> WR, then DRAIN the rest.
REQ-025 WR: act_wr_en=1 for exactly one cycle, addr=index, data=latched entry; cfg_wr_cnt+1; s_axis_tready=0; next IDLE or DRAIN per REQ-024.
REQ-026 Write latency: act_wr_en is asserted in the cycle after the beat-1 handshake.
REQ-027 DRAIN: s_axis_tready=1, beats discarded; return to IDLE after the tlast handshake.
REQ-028 m_axis_tvalid=0 in CAP, WR, DRAIN and matching IDLE cycles; m_axis data outputs are don't-care when tvalid=0.
REQ-029 Non-WR cycles: act_wr_en=0; act_wr_addr/act_wr_data hold their last values.
REQ-030 No combinational path from m_axis_tready to s_axis_tready outside IDLE/FWD.

Reset
REQ-031 On aresetn=0: state IDLE, act_wr_en=0, act_wr_addr=0, act_wr_data=0, cfg_wr_cnt=0, cfg_err_cnt=0, latched entry cleared.
REQ-032 Reset mid-packet aborts any write not yet strobed; the next beat after reset is treated as beat 0.

Structure
REQ-033 Opcode constant (WRITE=8'h01), header field offsets and FSM state encoding go in the shared rmt config package.
REQ-034 Single flat module, no sub-module; act_wr_* connects directly to the deparser action RAM write port (clka/addra/dina/wea/ena).

Verification
REQ-035 Matching packet, id 05, op 01, idx 3, beat1 0xA5..A5, tlast on beat1 -> one act_wr_en pulse 1 cycle later, addr 3, data {hdr nibble, A5..}, cfg_wr_cnt=1, m_axis_tvalid never 1.
REQ-036 Non-matching 3-beat packet (id 07), m_axis_tready toggling 1/0 -> all 3 beats appear unchanged in order, no write, counters unchanged.
REQ-037 Matching 1-beat packet (tlast on beat 0) -> no write, cfg_err_cnt=1; 256 such packets -> cfg_err_cnt=255.
REQ-038 Matching op 02, 4 beats -> all beats accepted and dropped, no write, next packet handled normally.
REQ-039 Matching 4-beat op-01 packet -> one write from beat 1, beats 2-3 drained, back-to-back following packet accepted without gap loss.
REQ-040 aresetn low for 1 cycle between beat 0 and beat 1 of a write -> no act_wr_en, counters 0, following beat treated as header.

Source files
------------

// File: rtl/depar_cfg_ctrl_pkg.sv
// Shared configuration package for the deparser action-table control path.
// Holds the opcode constants, beat-0 header field offsets and the FSM encoding.
package depar_cfg_ctrl_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;

    // Beat-0 header layout: {.., entry_hi[23:20], index[19:16], opcode[15:8], module_id[7:0]}
    localparam int unsigned HDR_ID_LSB  = 0;
    localparam int unsigned HDR_OP_LSB  = 8;
    localparam int unsigned HDR_IDX_LSB = 16;
    localparam int unsigned HDR_NIB_LSB = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_CAP,
        ST_WR,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/depar_cfg_ctrl.sv
// Deparser control-stream filter: forwards foreign control packets and turns
// matching write packets into single-cycle action-table writes.
module depar_cfg_ctrl
    import depar_cfg_ctrl_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  MODULE_ID          = 8'h05,
    parameter int unsigned C_ACT_WIDTH        = 260,
    parameter int unsigned C_ACT_ADDR_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              aresetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic                              act_wr_en,
    output logic [C_ACT_ADDR_WIDTH-1:0]       act_wr_addr,
    output logic [C_ACT_WIDTH-1:0]            act_wr_data,
    output logic [7:0]                        cfg_wr_cnt,
    output logic [7:0]                        cfg_err_cnt
);

    localparam int unsigned NIB_W = C_ACT_WIDTH - C_AXIS_DATA_WIDTH;

    state_e                         state_q;
    logic                           drain_after_q;
    logic [C_ACT_ADDR_WIDTH-1:0]    idx_q;
    logic [NIB_W-1:0]               nib_q;
    logic                           act_wr_en_q;
    logic [C_ACT_ADDR_WIDTH-1:0]    act_wr_addr_q;
    logic [C_ACT_WIDTH-1:0]         act_wr_data_q;
    logic [7:0]                     wr_cnt_q;
    logic [7:0]                     err_cnt_q;

    logic                           hdr_match;
    logic [7:0]                     hdr_op;

    assign hdr_match = (s_axis_tdata[HDR_ID_LSB +: 8] == MODULE_ID);
    assign hdr_op    = s_axis_tdata[HDR_OP_LSB +: 8];

    // m_axis data is a plain wire copy; m_axis_tvalid qualifies it.
    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tuser = s_axis_tuser;
    assign m_axis_tlast = s_axis_tlast;

    // m_axis_tready reaches s_axis_tready only while passing a foreign packet.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid && hdr_match) begin
                    s_axis_tready = 1'b1;
                end else begin
                    s_axis_tready = m_axis_tready;
                    m_axis_tvalid = s_axis_tvalid;
                end
            end
            ST_FWD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
            end
            ST_CAP, ST_DRAIN: s_axis_tready = 1'b1;
            default:          s_axis_tready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            drain_after_q <= 1'b0;
            idx_q         <= '0;
            nib_q         <= '0;
            act_wr_en_q   <= 1'b0;
            act_wr_addr_q <= '0;
            act_wr_data_q <= '0;
            wr_cnt_q      <= '0;
            err_cnt_q     <= '0;
        end else begin
            act_wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        if (hdr_match) begin
                            idx_q <= s_axis_tdata[HDR_IDX_LSB +: C_ACT_ADDR_WIDTH];
                            nib_q <= s_axis_tdata[HDR_NIB_LSB +: NIB_W];
                            if (s_axis_tlast) begin
                                if (err_cnt_q != '1) begin
                                    err_cnt_q <= err_cnt_q + 8'd1;
                                end
                            end else if (hdr_op == OP_WRITE) begin
                                state_q <= ST_CAP;
                            end else begin
                                state_q <= ST_DRAIN;
                            end
                        end else if (m_axis_tready && !s_axis_tlast) begin
                            state_q <= ST_FWD;
                        end
                    end
                end
                ST_FWD: begin
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CAP: begin
                    // Strobe and count are registered here so both are visible during WR.
                    if (s_axis_tvalid) begin
                        act_wr_en_q   <= 1'b1;
                        act_wr_addr_q <= idx_q;
                        act_wr_data_q <= {nib_q, s_axis_tdata};
                        wr_cnt_q      <= wr_cnt_q + 8'd1;
                        drain_after_q <= ~s_axis_tlast;
                        state_q       <= ST_WR;
                    end
                end
                ST_WR: begin
                    state_q <= drain_after_q ? ST_DRAIN : ST_IDLE;
                end
                ST_DRAIN: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign act_wr_en   = act_wr_en_q;
    assign act_wr_addr = act_wr_addr_q;
    assign act_wr_data = act_wr_data_q;
    assign cfg_wr_cnt  = wr_cnt_q;
    assign cfg_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_depar_cfg_ctrl.sv
// Directed scoreboard bench for depar_cfg_ctrl: forwarded beats and
// action-table writes are queued at drive time and checked as they emerge.
module tb_depar_cfg_ctrl;

    logic           clk = 1'b0;
    logic           aresetn;
    logic [255:0]   s_tdata;
    logic [31:0]    s_tkeep;
    logic [127:0]   s_tuser;
    logic           s_tvalid;
    logic           s_tlast;
    logic           s_tready;
    logic [255:0]   m_tdata;
    logic [31:0]    m_tkeep;
    logic [127:0]   m_tuser;
    logic           m_tvalid;
    logic           m_tlast;
    logic           m_tready;
    logic           act_wr_en;
    logic [3:0]     act_wr_addr;
    logic [259:0]   act_wr_data;
    logic [7:0]     cfg_wr_cnt;
    logic [7:0]     cfg_err_cnt;

    always #5 clk = ~clk;

    depar_cfg_ctrl #(
        .C_AXIS_DATA_WIDTH (256),
        .C_AXIS_TUSER_WIDTH(128),
        .MODULE_ID         (8'h05),
        .C_ACT_WIDTH       (260),
        .C_ACT_ADDR_WIDTH  (4)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .act_wr_en    (act_wr_en),
        .act_wr_addr  (act_wr_addr),
        .act_wr_data  (act_wr_data),
        .cfg_wr_cnt   (cfg_wr_cnt),
        .cfg_err_cnt  (cfg_err_cnt)
    );

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic [127:0] u;
        logic         l;
    } beat_t;

    typedef struct {
        logic [3:0]   a;
        logic [259:0] d;
        int unsigned  c;
        logic [7:0]   n;
    } wr_t;

    beat_t       fwd_q[$];
    wr_t         wr_q[$];
    beat_t       eb;
    wr_t         ew;
    int          vecs = 0;
    int          errs = 0;
    int unsigned cyc = 0;
    logic        tog = 1'b0;
    logic [7:0]  exp_wr = '0;
    logic [7:0]  exp_err = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (tog) begin
            #1 m_tready = ~m_tready;
        end
    end

    task automatic check(input string tag, input logic [419:0] obs, input logic [419:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, between driver updates.
    always @(negedge clk) begin
        if (aresetn === 1'b1) begin
            if (m_tvalid && m_tready) begin
                if (fwd_q.size() == 0) begin
                    check("unexpected_fwd_beat", {m_tvalid, m_tready}, 2'b00);
                end else begin
                    eb = fwd_q.pop_front();
                    check("fwd_beat", {m_tdata, m_tkeep, m_tuser, m_tlast},
                          {eb.d, eb.k, eb.u, eb.l});
                end
            end
            if (act_wr_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_act_wr_en", act_wr_en, 1'b0);
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_addr",  act_wr_addr, ew.a);
                    check("wr_data",  act_wr_data, ew.d);
                    check("wr_cycle", cyc, ew.c);
                    check("wr_cnt",   cfg_wr_cnt, ew.n);
                end
            end
        end
    end

    function automatic logic [255:0] hdr(input logic [7:0] id, input logic [7:0] op,
                                         input logic [3:0] idx, input logic [3:0] nib);
        logic [255:0] d;
        d = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        d[7:0]   = id;
        d[15:8]  = op;
        d[19:16] = idx;
        d[23:20] = nib;
        return d;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Presents one beat until it is accepted; hs is the cycle whose rising edge takes it.
    task automatic send(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u,
                        input logic l, output int unsigned hs);
        int unsigned n;
        s_tdata  = d;
        s_tkeep  = k;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("handshake_timeout", s_tready, 1'b1);
        hs = cyc;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_drop(input logic [255:0] d, input logic l);
        int unsigned hs;
        send(d, $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, l, hs);
    endtask

    task automatic send_fwd(input logic [255:0] d, input logic l);
        beat_t b;
        int unsigned hs;
        b.d = d;
        b.k = $urandom();
        b.u = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.l = l;
        fwd_q.push_back(b);
        send(b.d, b.k, b.u, b.l, hs);
    endtask

    task automatic send_wr_beat(input logic [255:0] d, input logic l,
                                input logic [3:0] idx, input logic [3:0] nib);
        wr_t w;
        int unsigned hs;
        send(d, $urandom(), {$urandom(), $urandom(), $urandom(), $urandom()}, l, hs);
        exp_wr = exp_wr + 8'd1;
        w.a = idx;
        w.d = {nib, d};
        w.c = hs + 1;
        w.n = exp_wr;
        wr_q.push_back(w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] a5;
        a5 = {8{32'hA5A5_A5A5}};
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en",   act_wr_en,   1'b0);
        check("rst_wr_addr", act_wr_addr, 4'h0);
        check("rst_wr_data", act_wr_data, 260'h0);
        check("rst_wr_cnt",  cfg_wr_cnt,  8'd0);
        check("rst_err_cnt", cfg_err_cnt, 8'd0);
        check("rst_m_tvalid", m_tvalid,   1'b0);
        @(posedge clk);
        #1 aresetn = 1'b1;
        idle(2);

        // Single write; downstream stalled to show the capture path ignores it.
        m_tready = 1'b0;
        send_drop(hdr(8'h05, 8'h01, 4'd3, 4'hA), 1'b0);
        send_wr_beat(a5, 1'b1, 4'd3, 4'hA);
        idle(3);
        check("t1_wr_cnt",  cfg_wr_cnt,  exp_wr);
        check("t1_err_cnt", cfg_err_cnt, exp_err);
        check("t1_wr_hold_addr", act_wr_addr, 4'd3);
        check("t1_wr_hold_data", act_wr_data, {4'hA, a5});
        m_tready = 1'b1;

        // Foreign 3-beat packet with downstream ready toggling, then a 1-beat one.
        tog = 1'b1;
        send_fwd(hdr(8'h07, 8'h01, 4'd2, 4'h1), 1'b0);
        send_fwd(hdr(8'h05, 8'h01, 4'd4, 4'h2), 1'b0);
        send_fwd(rnd256(), 1'b1);
        tog = 1'b0;
        @(posedge clk);
        #2 m_tready = 1'b1;
        send_fwd(hdr(8'h09, 8'h02, 4'd1, 4'h3), 1'b1);
        idle(2);
        check("t2_wr_cnt",  cfg_wr_cnt,  exp_wr);
        check("t2_err_cnt", cfg_err_cnt, exp_err);

        // Malformed single-beat packets: count saturates.
        send_drop(hdr(8'h05, 8'h01, 4'd6, 4'h6), 1'b1);
        exp_err = 8'd1;
        check("t3_err_cnt_1", cfg_err_cnt, exp_err);
        for (int i = 0; i < 255; i++) begin
            send_drop(hdr(8'h05, 8'($urandom()), 4'($urandom()), 4'h0), 1'b1);
        end
        exp_err = 8'd255;
        idle(1);
        check("t3_err_cnt_sat", cfg_err_cnt, exp_err);
        check("t3_wr_cnt", cfg_wr_cnt, exp_wr);

        // Non-write opcode: 4 beats dropped, then a normal write.
        send_drop(hdr(8'h05, 8'h02, 4'd7, 4'h7), 1'b0);
        send_drop(hdr(8'h05, 8'h01, 4'd8, 4'h8), 1'b0);
        send_drop(hdr(8'h05, 8'h01, 4'd8, 4'h8), 1'b0);
        send_drop(hdr(8'h05, 8'h01, 4'd8, 4'h8), 1'b1);
        send_drop(hdr(8'h05, 8'h01, 4'd9, 4'h5), 1'b0);
        send_wr_beat(rnd256(), 1'b1, 4'd9, 4'h5);
        idle(3);
        check("t4_wr_cnt", cfg_wr_cnt, exp_wr);
        check("t4_err_cnt", cfg_err_cnt, exp_err);

        // 4-beat write packet with trailing beats drained, then back-to-back foreign packet.
        send_drop(hdr(8'h05, 8'h01, 4'hC, 4'hE), 1'b0);
        send_wr_beat(rnd256(), 1'b0, 4'hC, 4'hE);
        send_drop(hdr(8'h05, 8'h01, 4'd1, 4'h1), 1'b0);
        send_drop(rnd256(), 1'b1);
        send_fwd(hdr(8'h33, 8'h01, 4'd2, 4'h2), 1'b0);
        send_fwd(rnd256(), 1'b1);
        idle(3);
        check("t5_wr_cnt", cfg_wr_cnt, exp_wr);

        // Reset between header and payload: pending write abandoned.
        send_drop(hdr(8'h05, 8'h01, 4'd5, 4'hB), 1'b0);
        aresetn = 1'b0;
        @(posedge clk);
        #1 aresetn = 1'b1;
        exp_wr  = '0;
        exp_err = '0;
        check("t6_rst_wr_cnt",  cfg_wr_cnt,  exp_wr);
        check("t6_rst_err_cnt", cfg_err_cnt, exp_err);
        check("t6_rst_wr_data", act_wr_data, 260'h0);
        send_fwd(a5, 1'b1);
        idle(3);
        check("t6_wr_cnt",  cfg_wr_cnt,  exp_wr);
        check("t6_err_cnt", cfg_err_cnt, exp_err);

        check("fwd_q_drained", fwd_q.size(), 0);
        check("wr_q_drained",  wr_q.size(),  0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
